fetch_stage: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the combinational instruction ROM (8-bit address in, 9-bit instruction out).
- Owns the program counter and drives the ROM address.
- Registers the returned instruction into the IF/ID register consumed by decode.
- Handles start, stall, branch redirect (absolute or PC-relative) and halt detection.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_next.sv | 27 ++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, defaults and state encoding for the instruction-fetch stage.
package fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int INSN_W = 9;
  localparam int PERF_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT  = '0;
  localparam logic [INSN_W-1:0] HALT_INSN_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection: sequential increment, absolute branch, or ir_pc-relative branch.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] ir_pc_i,
  input  logic              branch_take_i,
  input  logic              branch_rel_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  logic signed [ADDR_W-1:0] offset;
  logic signed [ADDR_W-1:0] rel_target;

  // Same-width signed add gives the modulo-2^ADDR_W wrap for free.
  assign offset     = $signed(branch_target_i);
  assign rel_target = $signed(ir_pc_i) + offset;

  always_comb begin
    pc_next_o = pc_i + ADDR_W'(1);
    if (branch_take_i) begin
      pc_next_o = branch_rel_i ? $unsigned(rel_target) : branch_target_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM, fills the IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSN_W-1:0] HALT_INSN = HALT_INSN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_take,
  input  logic              branch_rel,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INSN_W-1:0] rom_instr,
  output logic [INSN_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              running,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_bubble_cnt
`endif
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [INSN_W-1:0] ir_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              ir_valid_q;
  logic              fetch_go;

  fetch_pc_next u_pc_next (
    .pc_i            (pc_q),
    .ir_pc_i         (ir_pc_q),
    .branch_take_i   (branch_take),
    .branch_rel_i    (branch_rel),
    .branch_target_i (branch_target),
    .pc_next_o       (pc_d)
  );

  assign fetch_go = (state_q == RUN) && !branch_take && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          ir_valid_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
          end
        end
        RUN: begin
          if (branch_take) begin
            pc_q       <= pc_d;
            ir_valid_q <= 1'b0;
          end else if (!stall) begin
            ir_q       <= rom_instr;
            ir_pc_q    <= pc_q;
            ir_valid_q <= 1'b1;
            // The halt word is latched but the PC stays parked on it.
            if (rom_instr == HALT_INSN) begin
              state_q <= HALT;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign running  = (state_q == RUN);
  assign halted   = (state_q == HALT);

`ifdef FETCH_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

  logic [PERF_W-1:0] fetch_cnt_q;
  logic [PERF_W-1:0] bubble_cnt_q;
  logic              bubble_evt;

  // A stall only costs a bubble when it is holding an empty IF/ID register.
  assign bubble_evt = (state_q == RUN) && (branch_take || (stall && !ir_valid_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (start && (state_q != RUN)) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (fetch_go)   fetch_cnt_q  <= sat_inc(fetch_cnt_q);
      if (bubble_evt) bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic unused_fetch_go;
  assign unused_fetch_go = fetch_go;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected IF/ID contents,
// a negedge monitor pops and compares each newly latched instruction.
module tb_fetch_stage;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stall;
  logic       branch_take;
  logic       branch_rel;
  logic [7:0] branch_target;
  logic [7:0] rom_addr;
  logic [8:0] rom_instr;
  logic [8:0] ir;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       running;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_bubble_cnt;
`endif

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_take   (branch_take),
    .branch_rel    (branch_rel),
    .branch_target (branch_target),
    .rom_addr      (rom_addr),
    .rom_instr     (rom_instr),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .running       (running),
    .halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] rom [256];
  assign rom_instr = rom[rom_addr];

  typedef struct packed {
    logic [8:0] ir;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic stall_e = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_insn(input logic [8:0] i, input logic [7:0] p);
    exp_t e;
    e.ir = i;
    e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    branch_take = 1'b0;
  endtask

  // Park the pipe on a stall, then confirm every expected fetch was seen.
  task automatic drain(input string name);
    stall = 1'b1;
    @(negedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 0);
  endtask

  always @(posedge clk) stall_e <= stall;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && ir_valid && !stall_e) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_fetch: got ir_pc %0h with no expected entry", ir_pc);
      end else begin
        e = exp_q.pop_front();
        chk("mon_ir", 32'(ir), 32'(e.ir));
        chk("mon_ir_pc", 32'(ir_pc), 32'(e.pc));
      end
    end
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 9'(a) ^ 9'h0A5;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    branch_take = 1'b0;
    branch_rel = 1'b0;
    branch_target = 8'h00;
    tick();
    tick();
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_ir", 32'(ir), 0);
    reset = 1'b0;
    tick();
    chk("idle_frozen", 32'(rom_addr), 0);

    // Sequential fetch with a 3-cycle stall at ir_pc = 2
    expect_insn(9'h0A5, 8'h00); expect_insn(9'h0A4, 8'h01); expect_insn(9'h0A7, 8'h02);
    expect_insn(9'h0A6, 8'h03); expect_insn(9'h0A1, 8'h04); expect_insn(9'h0A0, 8'h05);
    pulse_start();
    chk("start_running", 32'(running), 1);
    chk("start_no_valid_yet", 32'(ir_valid), 0);
    tick();
    chk("first_valid_2_edges", 32'(ir_valid), 1);
    tick();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_ir_pc", 32'(ir_pc), 2);
      chk("stall_ir", 32'(ir), 32'h0A7);
      chk("stall_rom_addr", 32'(rom_addr), 3);
    end
    stall = 1'b0;
    tick(); tick(); tick();

    // Absolute branch to 0x40 while stalled: branch wins, one bubble
    expect_insn(9'h0E5, 8'h40); expect_insn(9'h0E4, 8'h41);
    stall = 1'b1; branch_take = 1'b1; branch_rel = 1'b0; branch_target = 8'h40;
    tick();
    chk("abs_bubble", 32'(ir_valid), 0);
    chk("abs_rom_addr", 32'(rom_addr), 32'h40);
    stall = 1'b0; branch_take = 1'b0;
    tick(); tick();

    // Return to 0, then relative -2 from ir_pc = 1 lands on 0xFF and wraps
    expect_insn(9'h0A5, 8'h00); expect_insn(9'h0A4, 8'h01);
    branch_take = 1'b1; branch_target = 8'h00;
    tick();
    branch_take = 1'b0;
    tick(); tick();
    expect_insn(9'h05A, 8'hFF); expect_insn(9'h0A5, 8'h00); expect_insn(9'h0A4, 8'h01);
    branch_take = 1'b1; branch_rel = 1'b1; branch_target = 8'hFE;
    tick();
    chk("rel_rom_addr", 32'(rom_addr), 32'hFF);
    branch_take = 1'b0; branch_rel = 1'b0;
    tick();
    chk("wrap_rom_addr", 32'(rom_addr), 0);
    tick(); tick();
    drain("drain_branch");

    // Halt word at address 3
    rom[3] = 9'h1FF;
    reset_pulse();
    expect_insn(9'h0A5, 8'h00); expect_insn(9'h0A4, 8'h01);
    expect_insn(9'h0A7, 8'h02); expect_insn(9'h1FF, 8'h03);
    pulse_start();
    tick(); tick(); tick();
    tick();
    chk("halt_latched_valid", 32'(ir_valid), 1);
    chk("halt_latched_ir", 32'(ir), 32'h1FF);
    tick();
    chk("halt_valid_drop", 32'(ir_valid), 0);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_not_running", 32'(running), 0);
    chk("halt_rom_addr", 32'(rom_addr), 3);
    branch_take = 1'b1; branch_target = 8'h10;
    tick();
    branch_take = 1'b0;
    chk("halt_branch_ignored", 32'(rom_addr), 3);
    chk("halt_ir_frozen", 32'(ir), 32'h1FF);
    expect_insn(9'h0A5, 8'h00); expect_insn(9'h0A4, 8'h01);
    pulse_start();
    chk("restart_running", 32'(running), 1);
    chk("restart_halted", 32'(halted), 0);
    chk("restart_rom_addr", 32'(rom_addr), 0);
    tick(); tick();
    drain("drain_halt_a");

    // Branch in the cycle the halt word is on rom_instr: no halt
    reset_pulse();
    expect_insn(9'h0A5, 8'h00); expect_insn(9'h0A4, 8'h01);
    expect_insn(9'h0A7, 8'h02); expect_insn(9'h0E5, 8'h40);
    pulse_start();
    tick(); tick(); tick();
    branch_take = 1'b1; branch_rel = 1'b0; branch_target = 8'h40;
    tick();
    branch_take = 1'b0;
    chk("haltb_not_halted", 32'(halted), 0);
    chk("haltb_running", 32'(running), 1);
    chk("haltb_bubble", 32'(ir_valid), 0);
    tick();
    drain("drain_halt_b");

    // Asynchronous reset between edges while running
    rom[3] = 9'h0A6;
    expect_insn(9'h0E4, 8'h41); expect_insn(9'h0E7, 8'h42);
    stall = 1'b0;
    tick(); tick();
    @(negedge clk);
    #1;
`ifdef FETCH_PERF_EN
    chk("perf_fetch_run", 32'(perf_fetch_cnt), 6);
    chk("perf_bubble_run", 32'(perf_bubble_cnt), 1);
`endif
    reset = 1'b1;
    #1;
    chk("arst_ir_valid", 32'(ir_valid), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_ir", 32'(ir), 0);
    chk("arst_ir_pc", 32'(ir_pc), 0);
    chk("arst_rom_addr", 32'(rom_addr), 0);
    chk("arst_queue_empty", 32'(exp_q.size()), 0);
`ifdef FETCH_PERF_EN
    chk("arst_perf_fetch", 32'(perf_fetch_cnt), 0);
    chk("arst_perf_bubble", 32'(perf_bubble_cnt), 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
